bsg_fifo_tracker_count: RTL
===========================

// Module: bsg_fifo_tracker_count
// PURPOSE
//  Pointer/occupancy tracker for a 1R1W FIFO built around an external RAM; generalises the 2^n-only tracker.
//  Supports any depth, with explicit wrap of non-power-of-two pointers.
//  Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow errors.
//  Sits between the FIFO's ready/valid logic and the RAM address ports.
// PARAMETERS
//  els_p              16          FIFO depth in entries; any value >= 2
//  almost_full_lp_p   els_p-2     almost_full_o asserted when count >= this value; range 1..els_p
//  almost_empty_lp_p  2           almost_empty_o asserted when count <= this value; range 0..els_p-1
//  ptr_width_lp       $clog2(els_p)    derived localparam; pointer width
//  cnt_width_lp       $clog2(els_p+1)  derived localparam; count width
// PORTS
//  clk_i           in   1             clock
//  reset_n_i       in   1             one clock; reset is asynchronous and active-low
//  enq_i           in   1             write request this cycle
//  deq_i           in   1             read request this cycle
//  clear_err_i     in   1             synchronous clear of the sticky error flags
//  wptr_r_o        out  ptr_width_lp  registered write pointer
//  rptr_r_o        out  ptr_width_lp  registered read pointer
//  rptr_n_o        out  ptr_width_lp  next read pointer (combinational; for sync-read RAM address)
//  count_o         out  cnt_width_lp  registered occupancy, 0..els_p
//  full_o          out  1             count_o == els_p
//  empty_o         out  1             count_o == 0
//  almost_full_o   out  1             count_o >= almost_full_lp_p
//  almost_empty_o  out  1             count_o <= almost_empty_lp_p
//  overflow_o      out  1             sticky: an enq was rejected
//  underflow_o     out  1             sticky: a deq was rejected
// BEHAVIOUR
//  - Reset (async assert, sync deassert in the surrounding design) drives these outputs:
//    wptr=rptr=count=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0 (for almost_full_lp_p >= 1), errors=0.
//  - Acceptance, evaluated on current registered state:
//    deq_acc = deq_i & ~empty_o
//    enq_acc = enq_i & (~full_o | deq_acc)   (enq into a full FIFO is accepted only if a deq is accepted in the same cycle)
//  - Rejected enq sets overflow_o. Rejected deq sets underflow_o. Neither pointer nor count moves for a rejected op.
//  - Empty FIFO with enq_i & deq_i: deq rejected (underflow set), enq accepted, count 0->1.
//  - Pointer increment: ptr==els_p-1 -> 0, else ptr+1. Power-of-two els_p needs no special logic.
//  - rptr_n_o = deq_acc ? inc(rptr_r_o) : rptr_r_o. Zero-cycle path from deq_i; the registered rptr equals it next cycle.
//  - count_n = count + enq_acc - deq_acc. count never leaves 0..els_p.
//  - full/empty/almost flags come from registered state only; no comb path from enq_i/deq_i to the flags.
//  - Latency: an accepted op is reflected in wptr/rptr/count/flags one cycle after the clock edge.
//  - Sticky errors:
//    - hold until clear_err_i or reset
//    - same-cycle clear_err_i and a new violation: the flag stays set (set wins)
//  - Invariant: (wptr - rptr) mod els_p == count mod els_p; wptr==rptr iff count in {0, els_p}.
//  - reset_n_i low mid-operation: all state returns to reset values immediately (async); the in-flight op is lost.
// STRUCTURE
//  - Sub-module bsg_circular_ptr_wrap #(els_p): inc_i, ptr_r_o, ptr_n_o; arbitrary-modulus wrap; instanced for rptr and wptr.
//  - Shared package bsg_fifo_tracker_pkg:
//    - bsg_fifo_status_s typedef {full, empty, almost_full, almost_empty, overflow, underflow}
//    - default threshold constants
//  - Elaboration-time asserts: els_p>=2, almost_empty_lp_p < almost_full_lp_p <= els_p.
// TESTING
//  1. Parameters els_p=5, af=4, ae=1. Reset, then enq x5 -> count 1,2,3,4,5; almost_full_o at count 4; full_o at 5; wptr 1,2,3,4,0.
//  2. From full, enq_i&deq_i together -> both accepted, count stays 5, wptr 0->1, rptr 0->1, overflow_o stays 0.
//  3. From full, enq_i alone -> rejected, wptr/count unchanged, overflow_o=1 next cycle; stays set until clear_err_i pulse.
//  4. From empty, deq_i alone -> underflow_o=1, rptr_n_o==rptr_r_o. From empty, enq_i&deq_i -> count 1, underflow_o=1.
//  5. Wrap: 12 enq/deq pairs interleaved at els_p=5 -> rptr_n_o sequence 1,2,3,4,0,1...; invariant holds every cycle.
//  6. Assert reset_n_i mid-burst (count=3) -> all outputs at reset values before the next clock edge; random enq/deq vs scoreboard.

Source files
------------

// File: rtl/bsg_fifo_tracker_pkg.sv
// Shared types and default thresholds for the FIFO pointer/occupancy tracker.
package bsg_fifo_tracker_pkg;

    localparam int unsigned default_els_c          = 16;
    localparam int unsigned default_almost_empty_c = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } bsg_fifo_status_s;

    // Two entries of headroom by default; never below 1 so the flag stays meaningful.
    function automatic int unsigned default_almost_full(input int unsigned els);
        return (els > 2) ? els - 2 : 1;
    endfunction

endpackage

// File: rtl/bsg_circular_ptr_wrap.sv
// Circular pointer with explicit wrap at els_p-1; works for any modulus >= 2.
module bsg_circular_ptr_wrap #(
    parameter  int unsigned els_p    = 16,
    localparam int unsigned width_lp = $clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                inc_i,
    output logic [width_lp-1:0] ptr_r_o,
    output logic [width_lp-1:0] ptr_n_o
);

    localparam logic [width_lp-1:0] last_ptr = width_lp'(els_p - 1);

    logic [width_lp-1:0] ptr_r;

    always_comb begin
        ptr_n_o = ptr_r;
        if (inc_i) begin
            ptr_n_o = (ptr_r == last_ptr) ? '0 : ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_n_o;
        end
    end

    assign ptr_r_o = ptr_r;

endmodule

// File: rtl/bsg_fifo_tracker_count.sv
// Read/write pointer, occupancy count, threshold flags and sticky error tracking
// for a 1R1W FIFO of arbitrary depth built around an external RAM.
module bsg_fifo_tracker_count
    import bsg_fifo_tracker_pkg::*;
#(
    parameter  int unsigned els_p             = default_els_c,
    parameter  int unsigned almost_full_lp_p  = default_almost_full(els_p),
    parameter  int unsigned almost_empty_lp_p = default_almost_empty_c,
    localparam int unsigned ptr_width_lp      = $clog2(els_p),
    localparam int unsigned cnt_width_lp      = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_i,
    input  logic                    deq_i,
    input  logic                    clear_err_i,
    output logic [ptr_width_lp-1:0] wptr_r_o,
    output logic [ptr_width_lp-1:0] rptr_r_o,
    output logic [ptr_width_lp-1:0] rptr_n_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    if (els_p < 2) begin : g_bad_depth
        $error("bsg_fifo_tracker_count: els_p must be at least 2");
    end
    if (!((almost_empty_lp_p < almost_full_lp_p) && (almost_full_lp_p <= els_p))) begin : g_bad_thr
        $error("bsg_fifo_tracker_count: need almost_empty < almost_full <= els_p");
    end

    localparam logic [cnt_width_lp-1:0] full_cnt = cnt_width_lp'(els_p);
    localparam logic [cnt_width_lp-1:0] af_cnt   = cnt_width_lp'(almost_full_lp_p);
    localparam logic [cnt_width_lp-1:0] ae_cnt   = cnt_width_lp'(almost_empty_lp_p);

    logic                    deq_acc;
    logic                    enq_acc;
    logic [cnt_width_lp-1:0] count_r;
    logic [cnt_width_lp-1:0] count_n;
    logic                    overflow_r;
    logic                    overflow_n;
    logic                    underflow_r;
    logic                    underflow_n;
    logic [ptr_width_lp-1:0] wptr_next;
    logic                    unused_wptr_next;
    bsg_fifo_status_s        status;

    // Flags derive from registered state only, so enq/deq never reach them combinationally.
    always_comb begin
        status              = '0;
        status.full         = (count_r == full_cnt);
        status.empty        = (count_r == '0);
        status.almost_full  = (count_r >= af_cnt);
        status.almost_empty = (count_r <= ae_cnt);
        status.overflow     = overflow_r;
        status.underflow    = underflow_r;
    end

    // A full FIFO still takes an enq when a deq frees a slot in the same cycle.
    assign deq_acc = deq_i & ~status.empty;
    assign enq_acc = enq_i & (~status.full | deq_acc);

    always_comb begin
        count_n = count_r;
        unique case ({enq_acc, deq_acc})
            2'b10:   count_n = count_r + 1'b1;
            2'b01:   count_n = count_r - 1'b1;
            default: count_n = count_r;
        endcase
    end

    // A new violation wins over a same-cycle clear.
    assign overflow_n  = (overflow_r & ~clear_err_i) | (enq_i & ~enq_acc);
    assign underflow_n = (underflow_r & ~clear_err_i) | (deq_i & ~deq_acc);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_n;
            overflow_r  <= overflow_n;
            underflow_r <= underflow_n;
        end
    end

    bsg_circular_ptr_wrap #(
        .els_p(els_p)
    ) u_wptr (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .inc_i    (enq_acc),
        .ptr_r_o  (wptr_r_o),
        .ptr_n_o  (wptr_next)
    );

    bsg_circular_ptr_wrap #(
        .els_p(els_p)
    ) u_rptr (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .inc_i    (deq_acc),
        .ptr_r_o  (rptr_r_o),
        .ptr_n_o  (rptr_n_o)
    );

    assign unused_wptr_next = ^wptr_next;

    assign count_o        = count_r;
    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign overflow_o     = status.overflow;
    assign underflow_o    = status.underflow;

endmodule
